// File: rtl/irq_seq.sv
// irq_seq: CPU-side interrupt entry/exit sequencer (push PC/PSW, vector, pop, return).
// Optional IRQ_SEQ_NEST_EN: set IE on handler entry so higher-priority takes can preempt.
module irq_seq #(
    parameter int DEPTH_MAX = 2,
    parameter int SP_STEP   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_irq_take,
    input  logic [15:0] i_irq_vector,
    input  logic        i_instr_bound,
    input  logic        i_reti,
    input  logic        i_ei,
    input  logic        i_di,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_psw,
    input  logic [15:0] i_sp,
    output logic        o_int_en,
    output logic        o_in_irq,
    output logic        o_irq_ret,
    output logic        o_stall,
    output logic        o_pc_load,
    output logic [15:0] o_pc_value,
    output logic        o_psw_load,
    output logic [15:0] o_psw_value,
    output logic        o_sp_load,
    output logic [15:0] o_sp_value,
    output logic        o_mem_sel,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_rdy
);

    localparam int            DW    = $clog2(DEPTH_MAX + 1);
    localparam logic [DW-1:0] DMAX  = DW'(DEPTH_MAX);
    localparam logic [DW-1:0] DONE  = DW'(1);
    localparam logic [15:0]   STEP1 = 16'(SP_STEP);
    localparam logic [15:0]   STEP2 = 16'(2 * SP_STEP);

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PC,
        PUSH_PSW,
        VECTOR,
        POP_PSW,
        POP_PC,
        RETURN
    } state_t;

    state_t        state_q, state_d;
    logic          ie_q, ie_d;
    logic          ie_rest_q, ie_rest_d;
    logic [DW-1:0] depth_q, depth_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   psw_q, psw_d;
    logic [15:0]   sp_q, sp_d;
    logic [15:0]   pcv_q, pcv_d;
    logic [15:0]   pswv_q, pswv_d;
    logic [15:0]   spv_q, spv_d;

    // PSW bit 15 is replaced by the saved IE on push.
    logic unused_psw15;
    assign unused_psw15 = i_psw[15];

    assign o_pc_value  = pcv_q;
    assign o_psw_value = pswv_q;
    assign o_sp_value  = spv_q;
    assign o_in_irq    = (depth_q != '0);

    // Next-state, handshake and pulse outputs.
    always_comb begin
        state_d     = state_q;
        ie_d        = ie_q;
        ie_rest_d   = ie_rest_q;
        depth_d     = depth_q;
        pc_d        = pc_q;
        psw_d       = psw_q;
        sp_d        = sp_q;
        pcv_d       = pcv_q;
        pswv_d      = pswv_q;
        spv_d       = spv_q;
        o_stall     = 1'b0;
        o_irq_ret   = 1'b0;
        o_pc_load   = 1'b0;
        o_psw_load  = 1'b0;
        o_sp_load   = 1'b0;
        o_mem_sel   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = 16'h0000;
        o_mem_wdata = 16'h0000;
        o_int_en    = ie_q & (state_q == IDLE) & i_instr_bound
                    & ~i_reti & (depth_q < DMAX);
        unique case (state_q)
            IDLE: begin
                if (i_irq_take) begin
                    o_stall = 1'b1;
                    pcv_d   = i_irq_vector;
                    pc_d    = i_pc;
                    psw_d   = {ie_q, i_psw[14:0]};
                    sp_d    = i_sp;
                    spv_d   = i_sp - STEP2;
                    ie_d    = 1'b0;
                    state_d = PUSH_PC;
                end else if (i_reti && i_instr_bound) begin
                    o_stall = 1'b1;
                    sp_d    = i_sp;
                    spv_d   = i_sp + STEP2;
                    state_d = POP_PSW;
                end else if (i_di) begin
                    ie_d = 1'b0;
                end else if (i_ei) begin
                    ie_d = 1'b1;
                end
            end
            PUSH_PC: begin
                o_stall     = 1'b1;
                o_mem_sel   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = sp_q - STEP1;
                o_mem_wdata = pc_q;
                if (i_mem_rdy) state_d = PUSH_PSW;
            end
            PUSH_PSW: begin
                o_stall     = 1'b1;
                o_mem_sel   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = sp_q - STEP2;
                o_mem_wdata = psw_q;
                if (i_mem_rdy) state_d = VECTOR;
            end
            VECTOR: begin
                o_stall   = 1'b1;
                o_pc_load = 1'b1;
                o_sp_load = 1'b1;
                if (depth_q < DMAX) depth_d = depth_q + DONE;
`ifdef IRQ_SEQ_NEST_EN
                ie_d = 1'b1;
`else
                ie_d = ie_q;
`endif
                state_d = IDLE;
            end
            POP_PSW: begin
                o_stall    = 1'b1;
                o_mem_sel  = 1'b1;
                o_mem_addr = sp_q;
                if (i_mem_rdy) begin
                    pswv_d    = {1'b0, i_mem_rdata[14:0]};
                    ie_rest_d = i_mem_rdata[15];
                    state_d   = POP_PC;
                end
            end
            POP_PC: begin
                o_stall    = 1'b1;
                o_mem_sel  = 1'b1;
                o_mem_addr = sp_q + STEP1;
                if (i_mem_rdy) begin
                    pcv_d   = i_mem_rdata;
                    state_d = RETURN;
                end
            end
            RETURN: begin
                o_stall    = 1'b1;
                o_pc_load  = 1'b1;
                o_psw_load = 1'b1;
                o_sp_load  = 1'b1;
                o_irq_ret  = 1'b1;
                ie_d       = ie_rest_q;
                if (depth_q != '0) depth_d = depth_q - DONE;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-context registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            ie_q      <= 1'b0;
            ie_rest_q <= 1'b0;
            depth_q   <= '0;
            pc_q      <= 16'h0000;
            psw_q     <= 16'h0000;
            sp_q      <= 16'h0000;
            pcv_q     <= 16'h0000;
            pswv_q    <= 16'h0000;
            spv_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            ie_q      <= ie_d;
            ie_rest_q <= ie_rest_d;
            depth_q   <= depth_d;
            pc_q      <= pc_d;
            psw_q     <= psw_d;
            sp_q      <= sp_d;
            pcv_q     <= pcv_d;
            pswv_q    <= pswv_d;
            spv_q     <= spv_d;
        end
    end

endmodule

// File: tb/tb_irq_seq.sv
// tb_irq_seq: randomized entry/return sequences against a stack-level model
// of the interrupt sequencer, with a variable-latency memory responder.
module tb_irq_seq;

    logic        clk = 1'b0;
    logic        i_rst, i_irq_take, i_instr_bound, i_reti, i_ei, i_di;
    logic [15:0] i_irq_vector, i_pc, i_psw, i_sp, i_mem_rdata;
    logic        i_mem_rdy;
    logic        o_int_en, o_in_irq, o_irq_ret, o_stall;
    logic        o_pc_load, o_psw_load, o_sp_load;
    logic [15:0] o_pc_value, o_psw_value, o_sp_value;
    logic        o_mem_sel, o_mem_we;
    logic [15:0] o_mem_addr, o_mem_wdata;

    always #5 clk = ~clk;

    irq_seq #(.DEPTH_MAX(2), .SP_STEP(2)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_irq_take(i_irq_take), .i_irq_vector(i_irq_vector),
        .i_instr_bound(i_instr_bound), .i_reti(i_reti),
        .i_ei(i_ei), .i_di(i_di),
        .i_pc(i_pc), .i_psw(i_psw), .i_sp(i_sp),
        .o_int_en(o_int_en), .o_in_irq(o_in_irq),
        .o_irq_ret(o_irq_ret), .o_stall(o_stall),
        .o_pc_load(o_pc_load), .o_pc_value(o_pc_value),
        .o_psw_load(o_psw_load), .o_psw_value(o_psw_value),
        .o_sp_load(o_sp_load), .o_sp_value(o_sp_value),
        .o_mem_sel(o_mem_sel), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_rdy(i_mem_rdy)
    );

`ifdef IRQ_SEQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    logic [15:0] mem [0:65535];
    bit          m_ie;
    int          m_depth;
    logic [15:0] m_sp;

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic bit m_int_en();
        return m_ie && (m_depth < 2);
    endfunction

    // Memory responder: fixed latency `lat` per transaction, checks holding.
    initial begin : memresp
        int          wcnt;
        logic [15:0] a0, w0;
        logic        we0;
        wcnt = 0; a0 = 0; w0 = 0; we0 = 0;
        forever begin
            @(negedge clk);
            if (i_mem_rdy) begin
                i_mem_rdy = 1'b0;
                wcnt = 0;
            end
            if (o_mem_sel && !i_rst) begin
                if (wcnt == 0) begin
                    a0 = o_mem_addr; w0 = o_mem_wdata; we0 = o_mem_we;
                end else begin
                    chk16("mem_addr_hold", o_mem_addr, a0);
                    chk16("mem_wdata_hold", o_mem_wdata, w0);
                    chk1("mem_we_hold", o_mem_we, we0);
                    chk1("mem_wait_stall", o_stall, 1'b1);
                end
                if (wcnt >= lat) begin
                    i_mem_rdy = 1'b1;
                    if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                    else i_mem_rdata = mem[o_mem_addr];
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic do_take(input logic [15:0] vec, input logic [15:0] pc,
                           input logic [15:0] psw);
        int          k;
        bit          found;
        logic [15:0] sp0;
        sp0 = m_sp;
        i_irq_take = 1'b1; i_irq_vector = vec; i_pc = pc; i_psw = psw;
        i_sp = sp0; i_instr_bound = 1'b1;
        #1;
        chk1("take_int_en", o_int_en, 1'b1);
        chk1("take_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        i_irq_take = 1'b0;
        i_irq_vector = 16'($urandom); i_pc = 16'($urandom);
        i_psw = 16'($urandom); i_sp = 16'($urandom);
        i_ei = 1'($urandom); i_di = 1'($urandom);
        found = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_pc_load) begin
                found = 1;
                break;
            end
            chk1("entry_stall", o_stall, 1'b1);
        end
        i_ei = 1'b0; i_di = 1'b0;
        chk1("entry_done", found, 1'b1);
        chk16("entry_cycles", 16'(k), 16'(2 * lat + 3));
        chk16("entry_pc", o_pc_value, vec);
        chk16("entry_sp", o_sp_value, sp0 - 16'd4);
        chk1("entry_sp_load", o_sp_load, 1'b1);
        chk1("entry_psw_load", o_psw_load, 1'b0);
        chk16("push_pc", mem[sp0 - 16'd2], pc);
        chk16("push_psw", mem[sp0 - 16'd4], {m_ie, psw[14:0]});
        m_ie = NEST;
        m_depth = (m_depth < 2) ? m_depth + 1 : 2;
        m_sp = sp0 - 16'd4;
        @(negedge clk);
        chk1("entry_pulse_end", o_pc_load, 1'b0);
        chk1("entry_in_irq", o_in_irq, m_depth != 0);
        chk1("entry_int_en", o_int_en, m_int_en());
        chk1("entry_idle_stall", o_stall, 1'b0);
    endtask

    task automatic do_reti();
        int          k;
        bit          found;
        logic [15:0] sp0, pw, pcw;
        sp0 = m_sp;
        pw = mem[sp0];
        pcw = mem[sp0 + 16'd2];
        i_reti = 1'b1; i_instr_bound = 1'b1; i_sp = sp0;
        #1;
        chk1("reti_int_en", o_int_en, 1'b0);
        chk1("reti_stall", o_stall, 1'b1);
        @(posedge clk); #1;
        i_reti = 1'b0; i_sp = 16'($urandom);
        i_ei = 1'($urandom); i_di = 1'($urandom);
        found = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (o_irq_ret) begin
                found = 1;
                break;
            end
            chk1("exit_stall", o_stall, 1'b1);
            chk1("exit_no_load", o_pc_load, 1'b0);
        end
        i_ei = 1'b0; i_di = 1'b0;
        chk1("exit_done", found, 1'b1);
        chk16("exit_cycles", 16'(k), 16'(2 * lat + 3));
        chk16("exit_psw", o_psw_value, {1'b0, pw[14:0]});
        chk16("exit_pc", o_pc_value, pcw);
        chk16("exit_sp", o_sp_value, sp0 + 16'd4);
        chk16("exit_loads", {13'd0, o_pc_load, o_psw_load, o_sp_load},
              16'h0007);
        m_ie = pw[15];
        m_depth = (m_depth > 0) ? m_depth - 1 : 0;
        m_sp = sp0 + 16'd4;
        @(negedge clk);
        chk1("exit_ret_pulse", o_irq_ret, 1'b0);
        chk1("exit_in_irq", o_in_irq, m_depth != 0);
        chk1("exit_int_en", o_int_en, m_int_en());
    endtask

    task automatic do_eidi(input bit ei, input bit di);
        i_ei = ei; i_di = di; i_instr_bound = 1'b1;
        @(posedge clk); #1;
        i_ei = 1'b0; i_di = 1'b0;
        if (di) m_ie = 1'b0;
        else if (ei) m_ie = 1'b1;
        @(negedge clk);
        chk1("eidi_int_en", o_int_en, m_int_en());
    endtask

    task automatic do_gate();
        i_instr_bound = 1'b0;
        #1 chk1("gate_bound", o_int_en, 1'b0);
        i_instr_bound = 1'b1;
        #1 chk1("gate_restore", o_int_en, m_int_en());
        i_reti = 1'b1;
        #1 chk1("gate_reti", o_int_en, 1'b0);
        i_reti = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  r;
        bit  found;
        i_rst = 1'b1; i_irq_take = 1'b0; i_instr_bound = 1'b0;
        i_reti = 1'b0; i_ei = 1'b0; i_di = 1'b0;
        i_irq_vector = 16'h0; i_pc = 16'h0; i_psw = 16'h0; i_sp = 16'h0;
        i_mem_rdata = 16'h0; i_mem_rdy = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        m_ie = 1'b0; m_depth = 0; m_sp = 16'h0400;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk16("rst_flags", {7'd0, o_int_en, o_in_irq, o_irq_ret, o_stall,
              o_pc_load, o_psw_load, o_sp_load, o_mem_sel, o_mem_we}, 16'h0);
        chk16("rst_pc_value", o_pc_value, 16'h0);
        chk16("rst_psw_value", o_psw_value, 16'h0);
        chk16("rst_sp_value", o_sp_value, 16'h0);
        chk16("rst_mem_addr", o_mem_addr, 16'h0);
        i_rst = 1'b0;

        do_eidi(1'b1, 1'b1);
        do_eidi(1'b1, 1'b0);
        do_gate();

        lat = 0;
        do_take(16'h0040, 16'h1234, 16'h0005);
        chk16("basic_wr_pc", mem[16'h03FE], 16'h1234);
        chk16("basic_wr_psw", mem[16'h03FC], 16'h8005);
        do_reti();
        chk1("basic_ret_ie", o_int_en, 1'b1);

        lat = 3;
        do_take(16'h0080, 16'h2222, 16'h7FFF);
        do_reti();

        lat = 0;
        do_take(16'h00C0, 16'h3000, 16'h0001);
        if (m_int_en()) do_take(16'h0100, 16'h4000, 16'h0002);
        while (m_depth > 0) do_reti();
        do_reti();

        m_sp = 16'h0002;
        do_eidi(1'b1, 1'b0);
        do_take(16'h0140, 16'h5555, 16'hAAAA);
        do_reti();

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 4);
            lat = $urandom_range(0, 3);
            case (r)
                0, 1: begin
                    if (m_int_en())
                        do_take(16'($urandom), 16'($urandom), 16'($urandom));
                    else
                        do_eidi(1'b1, 1'b0);
                end
                2: do_reti();
                3: do_eidi(1'($urandom), 1'($urandom));
                default: do_gate();
            endcase
        end

        lat = 2;
        while (m_depth > 0) do_reti();
        do_eidi(1'b1, 1'b0);
        i_irq_take = 1'b1; i_irq_vector = 16'h0200;
        i_pc = 16'h6000; i_psw = 16'h0003; i_sp = m_sp;
        @(posedge clk); #1;
        i_irq_take = 1'b0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_mem_sel && o_mem_addr == m_sp - 16'd4) begin
                found = 1;
                break;
            end
        end
        chk1("rst_mid_found", found, 1'b1);
        i_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk16("rst_mid_flags", {7'd0, o_int_en, o_in_irq, o_irq_ret, o_stall,
              o_pc_load, o_psw_load, o_sp_load, o_mem_sel, o_mem_we}, 16'h0);
        chk16("rst_mid_pc", o_pc_value, 16'h0);
        chk16("rst_mid_addr", o_mem_addr, 16'h0);
        i_rst = 1'b0;
        m_ie = 1'b0; m_depth = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("rst_mid_no_pc", o_pc_load, 1'b0);
            chk1("rst_mid_no_mem", o_mem_sel, 1'b0);
        end
        chk1("rst_mid_int_en", o_int_en, m_int_en());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_seq.md
Name: irq_seq

Overview:
CPU-side interrupt entry/exit sequencer. It sits in the core opposite the interrupt controller and drives the controller's int_en, in_irq and irq_ret inputs. It consumes irq_take and irq_vector and owns the interrupt-enable (IE) flag. On entry it pushes PC and PSW to the stack over the data-memory handshake, then redirects the PC. On RETI it pops both words, restores IE and pulses irq_ret.

Parameters:
DEPTH_MAX, 2, maximum tracked nesting depth; must match the controller's depth.
SP_STEP, 2, byte stride per 16-bit stack word.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset (synchronous, active-high)
i_irq_take  in  1  controller accepts an interrupt this cycle
i_irq_vector  in  16  handler address, valid with i_irq_take
i_instr_bound  in  1  core is at an instruction boundary
i_reti  in  1  RETI decoded, valid at a boundary
i_ei  in  1  EI instruction strobe
i_di  in  1  DI instruction strobe
i_pc  in  16  return address (next instruction)
i_psw  in  16  current PSW
i_sp  in  16  current stack pointer
o_int_en  out  1  to controller i_int_en
o_in_irq  out  1  to controller i_in_irq; depth != 0
o_irq_ret  out  1  to controller i_irq_ret; 1-cycle pulse
o_stall  out  1  freezes the core pipeline
o_pc_load  out  1  load o_pc_value into the PC
o_pc_value  out  16  new PC
o_psw_load  out  1  load o_psw_value into the PSW
o_psw_value  out  16  restored PSW
o_sp_load  out  1  load o_sp_value into the SP
o_sp_value  out  16  new SP
o_mem_sel  out  1  memory request
o_mem_we  out  1  1 = write, 0 = read
o_mem_addr  out  16  word address
o_mem_wdata  out  16  write data
i_mem_rdata  in  16  read data, valid with i_mem_rdy
i_mem_rdy  in  1  transaction complete (may be high in the same cycle as o_mem_sel)

Behaviour:
- Reset: all outputs 0; state IDLE; IE=0; depth=0; latched registers 0. A reset asserted mid-sequence aborts it immediately with no further memory access.
- o_int_en = IE & (state==IDLE) & i_instr_bound & ~i_reti & (depth<DEPTH_MAX). This gating makes every i_irq_take an accepted take, so a take is never lost.
- States: IDLE, PUSH_PC, PUSH_PSW, VECTOR, POP_PSW, POP_PC, RETURN.
- IDLE:
  - i_irq_take: latch vector, i_pc, i_psw, i_sp and IE; clear IE; go to PUSH_PC.
  - Else i_reti at a boundary: latch i_sp; go to POP_PSW.
  - Else i_di clears IE and i_ei sets IE; if both are asserted, DI wins.
  - EI/DI strobes outside IDLE are ignored.
- PUSH_PC: write latched PC to sp-2.
- PUSH_PSW: write {saved_IE, psw[14:0]} to sp-4. PSW bit 15 is reserved to carry IE.
- VECTOR (1 cycle):
  - o_pc_load=1 with the vector; o_sp_load=1 with sp-4.
  - depth increments, saturating at DEPTH_MAX.
  - Go to IDLE.
- POP_PSW: read sp.
  - On rdy: capture the word into o_psw_value as {0, rdata[14:0]}; restored IE = rdata[15].
- POP_PC: read sp+2.
  - On rdy: capture the word into o_pc_value.
- RETURN (1 cycle):
  - o_pc_load, o_psw_load and o_sp_load (sp+4) all =1; o_irq_ret=1.
  - IE takes the restored value; depth decrements, saturating at 0.
  - Go to IDLE.
- Memory handshake:
  - o_mem_sel, we, addr and wdata are held stable until i_mem_rdy is sampled high.
  - Exactly one transaction per PUSH/POP state; the state advances in the cycle rdy is seen.
  - o_mem_sel drops in the following state unless that state issues a new request.
- Timing:
  - o_stall=1 in every state other than IDLE, and combinationally in the IDLE cycle of a take or an accepted RETI.
  - Zero-wait memory: entry completes 3 cycles after the take (PUSH_PC, PUSH_PSW, VECTOR); exit completes 3 cycles after RETI.
- Arithmetic: all address and SP arithmetic is 16-bit modulo, so stack underflow and overflow wrap silently.
- RETI at depth 0: the pops are still performed; o_irq_ret still pulses; depth stays 0.
- o_pc_load, o_psw_load, o_sp_load and o_irq_ret are single-cycle pulses. o_*_value outputs are don't-care when not loaded but are held registered.

Optional Feature:
IRQ_SEQ_NEST_EN
- Defined: IE is forced to 1 in the VECTOR cycle, so higher-priority interrupts can preempt the handler immediately. Preemption is bounded by the depth<DEPTH_MAX gate.
- Undefined: IE stays 0 through the handler until RETI restores it or software executes EI, so there is no hardware nesting. The depth counter still runs and drives o_in_irq.

Test Plan:
- Basic entry: reset, EI, sp=0x0400, pc=0x1234, psw=0x0005, zero-wait memory; take with vector 0x0040.
  - Required: write 0x1234 to 0x03FE; write 0x8005 to 0x03FC; PC=0x0040 and SP=0x03FC at cycle 3; o_in_irq=1; o_int_en=0 (nest macro off).
- Return: RETI at sp=0x03FC, memory returning 0x8005 then 0x1234.
  - Required: PSW=0x0005, PC=0x1234, SP=0x0400; one-cycle o_irq_ret; IE=1; o_in_irq=0.
- Wait states: i_mem_rdy delayed 3 cycles per access.
  - Required: address and data held stable throughout; o_stall held; entry completes at cycle 9.
- Nesting (IRQ_SEQ_NEST_EN defined): second take in the cycle after VECTOR.
  - Required: depth=2 and o_int_en=0 while depth=2; after one RETI, depth=1 and o_int_en returns to 1.
- Reset mid-sequence: reset asserted during PUSH_PSW.
  - Required: next cycle o_mem_sel=0, all outputs 0; no PC load occurs.
- Gating: IE=1 with i_instr_bound=0, or with i_reti=1.
  - Required: o_int_en=0. With EI and DI in the same cycle: IE=0.
